// File: rtl/csr_access_sequencer.sv
// Serialises CSR read-modify-write, ecall/irq trap entry and mret return onto a
// single-read/single-write CSR RAM, and drives the resulting PC redirect.
module csr_access_sequencer #(
    parameter int          ADDR_W      = 10,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [31:0] ECALL_CAUSE = 32'd11,
    parameter logic [31:0] IRQ_CAUSE   = 32'h8000000B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_cmd,
    input  logic [11:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    input  logic              irq,
    input  logic              irq_en,
    input  logic [31:0]       irq_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        dbg_state
);

    // Request handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready only rises in IDLE with no pending irq or flush.

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_TEPC, S_TCAUSE, S_TVEC, S_RRD, S_RRET
    } state_t;

    localparam logic [2:0] CMD_W     = 3'd1;
    localparam logic [2:0] CMD_S     = 3'd2;
    localparam logic [2:0] CMD_C     = 3'd3;
    localparam logic [2:0] CMD_ECALL = 3'd4;
    localparam logic [2:0] CMD_MRET  = 3'd5;

    state_t              state;
    logic [2:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         pc_q;
    logic [31:0]         cause_q;
    logic                take_irq;
    logic                accept;
    logic [31:0]         new_val;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^req_addr[11:ADDR_W];
    assign take_irq  = irq & irq_en;
    assign req_ready = rst_n & (state == S_IDLE) & ~take_irq & ~flush;
    assign accept    = req_valid & req_ready;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Interrupt wins over any request presented in the same cycle.
                    if (take_irq) begin
                        pc_q    <= irq_pc;
                        cause_q <= IRQ_CAUSE;
                        state   <= S_TEPC;
                    end else if (accept) begin
                        cmd_q   <= req_cmd;
                        addr_q  <= req_addr[ADDR_W-1:0];
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        case (req_cmd)
                            CMD_W, CMD_S, CMD_C: state <= S_RD;
                            CMD_ECALL: begin
                                cause_q <= ECALL_CAUSE;
                                state   <= S_TEPC;
                            end
                            CMD_MRET: state <= S_RRD;
                            default:  state <= S_IDLE;
                        endcase
                    end
                end
                S_RD:     state <= S_WR;
                S_WR:     state <= S_IDLE;
                S_TEPC:   state <= S_TCAUSE;
                S_TCAUSE: state <= S_TVEC;
                S_TVEC:   state <= S_IDLE;
                S_RRD:    state <= S_RRET;
                S_RRET:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (cmd_q)
            CMD_S:   new_val = mem_rdata | wdata_q;
            CMD_C:   new_val = mem_rdata & ~wdata_q;
            default: new_val = wdata_q;
        endcase
    end

    // RAM read data arrives one cycle after mem_ren, so the WR/TVEC/RRET outputs
    // are taken straight from mem_rdata in the state that follows the read.
    always_comb begin
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ren        = 1'b0;
        mem_raddr      = '0;
        mem_wen        = 1'b0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        case (state)
            S_RD: begin
                mem_ren   = 1'b1;
                mem_raddr = addr_q;
            end
            S_WR: begin
                resp_valid = 1'b1;
                resp_rdata = mem_rdata;
                mem_wen    = (cmd_q == CMD_W) | (wdata_q != 32'd0);
                mem_waddr  = addr_q;
                mem_wdata  = new_val;
            end
            S_TEPC: begin
                mem_wen   = 1'b1;
                mem_waddr = MEPC_ADDR[ADDR_W-1:0];
                mem_wdata = pc_q;
            end
            S_TCAUSE: begin
                mem_wen   = 1'b1;
                mem_waddr = MCAUSE_ADDR[ADDR_W-1:0];
                mem_wdata = cause_q;
                mem_ren   = 1'b1;
                mem_raddr = MTVEC_ADDR[ADDR_W-1:0];
            end
            S_TVEC: begin
                redirect_valid = 1'b1;
                redirect_pc    = mem_rdata & ~32'h3;
            end
            S_RRD: begin
                mem_ren   = 1'b1;
                mem_raddr = MEPC_ADDR[ADDR_W-1:0];
            end
            S_RRET: begin
                redirect_valid = 1'b1;
                redirect_pc    = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Bench for csr_access_sequencer: CSR RAM model, transaction-level reference model
// feeding an expected queue, and a monitor that checks responses and redirects.
module tb_csr_access_sequencer;

    localparam int EW = 65;  // {is_redirect, data[31:0], cycle[31:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_cmd = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        irq = 1'b0;
    logic        irq_en = 1'b0;
    logic [31:0] irq_pc = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_ren;
    logic [9:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  dbg_state;

    csr_access_sequencer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .irq(irq), .irq_en(irq_en), .irq_pc(irq_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- CSR RAM (read returns old value on same-index write) ----------------
    logic [31:0] ram [1024];
    logic [31:0] rdata_q = '0;
    int          wen_cnt = 0;
    assign mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (mem_ren) rdata_q <= ram[mem_raddr];
        if (mem_wen) begin
            ram[mem_waddr] <= mem_wdata;
            wen_cnt        <= wen_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];
    logic [31:0]   csr_m [1024];
    int            busy = 0;   // cycles the sequencer stays non-idle after an accept
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic model_trap(input logic [31:0] pc, input logic [31:0] cause);
        csr_m[10'h341] = pc;
        csr_m[10'h342] = cause;
        exp_q.push_back({1'b1, csr_m[10'h305] & ~32'h3, 32'(cyc + 3)});
        busy = 3;
    endtask

    task automatic model_req();
        logic [9:0]  a;
        logic [31:0] old_v;
        logic [31:0] new_v;
        a = req_addr[9:0];
        old_v = csr_m[a];
        case (req_cmd)
            3'd1, 3'd2, 3'd3: begin
                new_v = (req_cmd == 3'd1) ? req_wdata :
                        (req_cmd == 3'd2) ? (old_v | req_wdata) : (old_v & ~req_wdata);
                if (req_cmd == 3'd1 || req_wdata != 0) csr_m[a] = new_v;
                exp_q.push_back({1'b0, old_v, 32'(cyc + 2)});
                busy = 2;
            end
            3'd4: model_trap(req_pc, 32'd11);
            3'd5: begin
                exp_q.push_back({1'b1, csr_m[10'h341], 32'(cyc + 2)});
                busy = 2;
            end
            default: ;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy = 0;
                exp_q.delete();
            end else begin
                if (busy > 0) busy--;
                else if (irq && irq_en) model_trap(irq_pc, 32'h8000000B);
                else if (req_valid && !flush) model_req();
                cyc++;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    task automatic check_out(input logic kind, input logic [31:0] data);
        logic [EW-1:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got data=%h at cycle %0d, required no output",
                     kind ? "redirect" : "resp", data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e[64] != kind || e[63:32] != data || e[31:0] != 32'(cyc)) begin
                n_bad++;
                $display("FAIL %s: got kind=%0d data=%h cycle=%0d, required kind=%0d data=%h cycle=%0d",
                         kind ? "redirect" : "resp", kind, data, cyc, e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_cmp++;
                if (req_ready != (busy == 0 && !(irq && irq_en) && !flush)) begin
                    n_bad++;
                    $display("FAIL req_ready: got %0d, required %0d at cycle %0d", req_ready,
                             (busy == 0 && !(irq && irq_en) && !flush), cyc);
                end
                if (resp_valid) check_out(1'b0, resp_rdata);
                if (redirect_valid) check_out(1'b1, redirect_pc);
            end
        end
    end

    // ---------------- driver / helper tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at posedge+#1; holds the request until the DUT takes it.
    task automatic drive_req(input logic [2:0] cmd, input logic [11:0] addr,
                             input logic [31:0] wdata, input logic [31:0] pc, input bit rnd_flush);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = pc;
        flush     = rnd_flush && ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                flush     = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            flush = rnd_flush && ($urandom_range(0, 3) == 0);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no acceptance in 60 cycles, required acceptance");
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc, input bit rnd_flush);
        @(posedge clk);
        #1;
        drive_req(cmd, addr, wdata, pc, rnd_flush);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy == 0 && exp_q.size() == 0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: got %0d outputs still pending, required 0", exp_q.size());
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 12'h305;
            1: return 12'h341;
            2: return 12'h342;
            3: return 12'h300;
            4: return 12'h700;
            5: return 12'hB05;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    int w0;
    int img_bad;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = '0;
            csr_m[i] = '0;
        end
        #3;
        check("rst_flags", {27'b0, resp_valid, redirect_valid, mem_ren, mem_wen, req_ready}, 32'd0);
        check("rst_data", resp_rdata | redirect_pc | mem_wdata | {22'b0, mem_raddr} | {22'b0, mem_waddr}, 32'd0);
        #20;
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // csrrw: mtvec=0x100, then RAM[0x300]=0x8 (old 0 returned at T+2)
        issue(3'd1, 12'h305, 32'h100, 32'h0, 1'b0);
        issue(3'd1, 12'h300, 32'h8, 32'h0, 1'b0);
        wait_idle();
        check("csrrw_ram", ram[10'h300], 32'h8);

        // csrrs with zero operand never writes; csrrc clears bits
        issue(3'd1, 12'h300, 32'hF0, 32'h0, 1'b0);
        wait_idle();
        w0 = wen_cnt;
        issue(3'd2, 12'h300, 32'h0, 32'h0, 1'b0);
        wait_idle();
        check("csrrs0_no_write", 32'(wen_cnt - w0), 32'd0);
        issue(3'd3, 12'h300, 32'h30, 32'h0, 1'b0);
        wait_idle();
        check("csrrc_ram", ram[10'h300], 32'hC0);

        // ecall: mtvec=0x203 -> redirect 0x200 at T+3
        issue(3'd1, 12'h305, 32'h203, 32'h0, 1'b0);
        issue(3'd4, 12'h000, 32'h0, 32'h44, 1'b0);
        wait_idle();
        check("ecall_mepc", ram[10'h341], 32'h44);
        check("ecall_mcause", ram[10'h342], 32'd11);

        // mret: redirect to MEPC at T+2, no writes
        issue(3'd1, 12'h341, 32'h48, 32'h0, 1'b0);
        wait_idle();
        w0 = wen_cnt;
        issue(3'd5, 12'h000, 32'h0, 32'h0, 1'b0);
        wait_idle();
        check("mret_no_write", 32'(wen_cnt - w0), 32'd0);

        // irq and request together: irq wins, request accepted afterwards
        @(posedge clk);
        #1;
        irq = 1'b1;
        irq_en = 1'b1;
        irq_pc = 32'h1234;
        fork
            drive_req(3'd2, 12'h300, 32'h1, 32'h50, 1'b0);
            begin
                @(posedge clk);
                #1;
                irq = 1'b0;
            end
        join
        wait_idle();
        check("irq_mcause", ram[10'h342], 32'h8000000B);
        check("irq_mepc", ram[10'h341], 32'h1234);
        check("irq_then_req_ram", ram[10'h300], 32'hC1);

        // async reset during TCAUSE: MEPC written, MCAUSE untouched
        issue(3'd4, 12'h000, 32'h0, 32'h88, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {27'b0, resp_valid, redirect_valid, mem_ren, mem_wen, req_ready}, 32'd0);
        csr_m[10'h342] = 32'h8000000B;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_mcause", ram[10'h342], 32'h8000000B);
        check("midrst_mepc", ram[10'h341], 32'h88);

        // flush in IDLE blocks acceptance
        @(posedge clk);
        #1;
        w0 = wen_cnt;
        flush = 1'b1;
        req_valid = 1'b1;
        req_cmd = 3'd1;
        req_addr = 12'h300;
        req_wdata = 32'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        wait_idle();
        check("flush_no_write", 32'(wen_cnt - w0), 32'd0);
        check("flush_ram", ram[10'h300], 32'hC1);

        // randomized traffic with flush and occasional interrupts
        for (int n = 0; n < 150; n++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
                irq = 1'b1;
                irq_en = 1'($urandom_range(0, 1));
                irq_pc = $urandom & ~32'h3;
                fork
                    drive_req(3'($urandom_range(0, 7)), pick_addr(), wd, $urandom & ~32'h3, 1'b1);
                    begin
                        @(posedge clk);
                        #1;
                        irq = 1'b0;
                    end
                join
            end else begin
                issue(3'($urandom_range(0, 7)), pick_addr(), wd, $urandom & ~32'h3, 1'b1);
            end
        end
        wait_idle();

        img_bad = 0;
        for (int i = 0; i < 1024; i++)
            if (ram[i] !== csr_m[i]) img_bad++;
        check("ram_image_mismatch_words", 32'(img_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
